mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 15: maximum ACCESS cycles without mem_ack before abort; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU access request, write enable.
REQ-007 cpu_addr / cpu_wdata  input  AW / DW  CPU address, write data.
REQ-008 cpu_rdata  output  DW  registered CPU read data.
REQ-009 cpu_done / cpu_err  output  1 / 1  one-cycle completion and timeout pulses.
REQ-010 ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_done, ld_err: loader port, same widths and meaning as CPU port.
REQ-011 ld_lock  input  1  when 1, CPU requests are not granted.
REQ-012 mem_en / mem_we  output  1 / 1  memory access strobe, write enable.
REQ-013 mem_addr / mem_wdata  output  AW / DW  memory address, write data.
REQ-014 mem_rdata / mem_ack  input  DW / 1  memory read data, access complete.
REQ-015 busy / owner  output  1 / 1  arbiter not IDLE; current owner (0 = CPU, 1 = loader), valid while busy.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-017 Requests SHALL be sampled only in IDLE; eligible = ld_req, or cpu_req with ld_lock = 0.
REQ-018 On an eligible request in IDLE, the winner's we/addr/wdata SHALL be latched into internal registers and the state SHALL go to ACCESS next cycle.
REQ-019 With both eligible, the grant SHALL go to the requester not granted last (round-robin); after reset the CPU wins the first tie.
REQ-020 In ACCESS, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL drive the latched values; in IDLE and RESP, mem_en and mem_we SHALL be 0.
REQ-021 Request latched in IDLE cycle N: mem_en SHALL be 1 from cycle N+1.
REQ-022 mem_ack = 1 in ACCESS cycle M SHALL move to RESP; the owner's done SHALL be 1 during cycle M+1 only; IDLE at M+2.
REQ-023 On an acknowledged read, mem_rdata at cycle M SHALL be captured into the owner's rdata, valid from M+1 and held until the owner's next completed read.
REQ-024 Writes and aborted accesses SHALL leave both rdata registers unchanged.
REQ-025 An 8-bit counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; reaching TIMEOUT SHALL move to RESP with the owner's err = 1 (done = 0) for one cycle.
REQ-026 Ack in the cycle the counter reaches TIMEOUT SHALL count as success (done, not err).
REQ-027 mem_ack outside ACCESS SHALL be ignored.
REQ-028 Requester input changes during ACCESS/RESP, including dropping req, SHALL NOT affect the in-flight access.
REQ-029 req still high in the IDLE cycle after RESP SHALL be treated as a new access; requesters clear req on the edge ending their done cycle.
REQ-030 ld_lock rising during a CPU access SHALL NOT abort it; lock applies from the next IDLE.
REQ-031 The non-owner's done/err SHALL remain 0 throughout.
REQ-032 busy SHALL be 1 in ACCESS and RESP; owner SHALL hold the granted requester until IDLE.

Reset
REQ-033 reset_n = 0 SHALL immediately force IDLE, counter 0, round-robin to CPU-first, and all outputs (including rdata) to 0.
REQ-034 Reset mid-access SHALL drop mem_en immediately, and no done/err pulse SHALL be issued for the aborted access.

Verification
REQ-035 CPU read at addr 0x40, ack after 2 ACCESS cycles with mem_rdata 0xDEADBEEF -> cpu_done pulse one cycle after ack, cpu_rdata = 0xDEADBEEF, ld_done stays 0.
REQ-036 cpu_req and ld_req both high from reset, ack immediately each access -> grants in order CPU, loader, CPU, loader.
REQ-037 ld_lock = 1 with both requesting -> only the loader is granted; CPU is granted in the first IDLE after ld_lock = 0.
REQ-038 CPU write 0x12345678 to 0x80 with mem_ack never asserted -> mem_en high 15 cycles, then cpu_err one-cycle pulse, cpu_rdata unchanged, back to IDLE.
REQ-039 Ack in the exact TIMEOUT cycle -> cpu_done = 1, cpu_err = 0.
REQ-040 reset_n low during ACCESS -> mem_en, busy, done and err all 0 in the same cycle; after release, first tie granted to CPU.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the CPU port, the loader port, the memory port and arbiter status.
// The master modport is the arbiter's view; the slave modport is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          cpu_err;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_done;
    logic          ld_err;
    logic          ld_lock;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          busy;
    logic          owner;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_err,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_rdata, ld_done, ld_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output busy, owner
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_err,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_rdata, ld_done, ld_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) round-robin arbiter for a single memory port with an
// access timeout. Three-state FSM: IDLE -> ACCESS -> RESP -> IDLE.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t        state_reg;
    logic          owner_reg;
    logic          prio_ld_reg;
    logic          busy_reg;
    logic          mem_en_reg;
    logic          mem_we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [7:0]    cnt_reg;
    logic [DW-1:0] cpu_rdata_reg;
    logic [DW-1:0] ld_rdata_reg;
    logic          cpu_done_reg;
    logic          cpu_err_reg;
    logic          ld_done_reg;
    logic          ld_err_reg;

    logic cpu_elig;
    logic ld_elig;
    logic grant_ld;

    assign cpu_elig = bus.cpu_req && !bus.ld_lock;
    assign ld_elig  = bus.ld_req;
    // prio_ld_reg is set whenever the CPU was the last requester granted
    assign grant_ld = ld_elig && (!cpu_elig || prio_ld_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            prio_ld_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= 8'd0;
            cpu_rdata_reg <= '0;
            ld_rdata_reg  <= '0;
            cpu_done_reg  <= 1'b0;
            cpu_err_reg   <= 1'b0;
            ld_done_reg   <= 1'b0;
            ld_err_reg    <= 1'b0;
        end else begin
            cpu_done_reg <= 1'b0;
            cpu_err_reg  <= 1'b0;
            ld_done_reg  <= 1'b0;
            ld_err_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cpu_elig || ld_elig) begin
                        state_reg   <= ACCESS;
                        owner_reg   <= grant_ld;
                        prio_ld_reg <= !grant_ld;
                        busy_reg    <= 1'b1;
                        mem_en_reg  <= 1'b1;
                        cnt_reg     <= 8'd0;
                        mem_we_reg  <= grant_ld ? bus.ld_we    : bus.cpu_we;
                        addr_reg    <= grant_ld ? bus.ld_addr  : bus.cpu_addr;
                        wdata_reg   <= grant_ld ? bus.ld_wdata : bus.cpu_wdata;
                    end
                end

                ACCESS: begin
                    if (bus.mem_ack) begin
                        state_reg  <= RESP;
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        if (owner_reg) begin
                            ld_done_reg <= 1'b1;
                            if (!mem_we_reg) ld_rdata_reg <= bus.mem_rdata;
                        end else begin
                            cpu_done_reg <= 1'b1;
                            if (!mem_we_reg) cpu_rdata_reg <= bus.mem_rdata;
                        end
                    end else if (cnt_reg + 8'd1 == TIMEOUT_CNT) begin
                        // An ack arriving in this same cycle takes the branch above instead
                        state_reg  <= RESP;
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        cnt_reg    <= cnt_reg + 8'd1;
                        if (owner_reg) ld_err_reg  <= 1'b1;
                        else           cpu_err_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end

                RESP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.cpu_rdata = cpu_rdata_reg;
    assign bus.cpu_done  = cpu_done_reg;
    assign bus.cpu_err   = cpu_err_reg;
    assign bus.ld_rdata  = ld_rdata_reg;
    assign bus.ld_done   = ld_done_reg;
    assign bus.ld_err    = ld_err_reg;
    assign bus.busy      = busy_reg;
    assign bus.owner     = owner_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_mem_arbiter;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          c_req, l_req, lock, c_we, l_we;
        logic [31:0] c_addr, l_addr, c_wd, l_wd;
        int          ack_at;      // ACCESS cycle (1-based) carrying mem_ack; 0 = never
        logic [31:0] rd;
        bit          scramble;    // wiggle inputs while the access is in flight
        bit          exp_grant, exp_owner, exp_ok;
        logic [31:0] exp_rd_cpu, exp_rd_ld;
    } txn_t;

    function automatic txn_t mk(bit cr, bit lr, bit lk, bit cwe, bit lwe,
                                logic [31:0] ca, logic [31:0] la, logic [31:0] cw, logic [31:0] lw,
                                int ack, logic [31:0] rd, bit sc, bit g, bit o, bit ok,
                                logic [31:0] erc, logic [31:0] erl);
        txn_t t;
        t.c_req = cr; t.l_req = lr; t.lock = lk; t.c_we = cwe; t.l_we = lwe;
        t.c_addr = ca; t.l_addr = la; t.c_wd = cw; t.l_wd = lw;
        t.ack_at = ack; t.rd = rd; t.scramble = sc;
        t.exp_grant = g; t.exp_owner = o; t.exp_ok = ok;
        t.exp_rd_cpu = erc; t.exp_rd_ld = erl;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
        bus.ld_lock = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Applies one request from IDLE and follows it through to the IDLE after RESP.
    task automatic run_txn(input txn_t t, input int idx);
        logic [31:0] ea, ew;
        bit          ewe, acked;
        bus.cpu_req = t.c_req; bus.cpu_we = t.c_we; bus.cpu_addr = t.c_addr; bus.cpu_wdata = t.c_wd;
        bus.ld_req  = t.l_req; bus.ld_we  = t.l_we; bus.ld_addr  = t.l_addr; bus.ld_wdata  = t.l_wd;
        bus.ld_lock = t.lock;
        bus.mem_ack = t.scramble ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.mem_rdata = $urandom;
        check("idle_busy", bus.busy, 0);
        check("idle_mem_en", bus.mem_en, 0);
        tick();
        if (!t.exp_grant) begin
            check("nogrant_busy", bus.busy, 0);
            check("nogrant_mem_en", bus.mem_en, 0);
            check("nogrant_pulses", {bus.cpu_done, bus.cpu_err, bus.ld_done, bus.ld_err}, 0);
            $display("txn %0d: no grant, busy=%0b", idx, bus.busy);
            clear_inputs();
            return;
        end
        ea  = t.exp_owner ? t.l_addr : t.c_addr;
        ew  = t.exp_owner ? t.l_wd   : t.c_wd;
        ewe = t.exp_owner ? t.l_we   : t.c_we;
        acked = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (t.scramble) begin
                bus.cpu_req = ($urandom_range(0, 1) == 1); bus.ld_req = ($urandom_range(0, 1) == 1);
                bus.ld_lock = ($urandom_range(0, 1) == 1); bus.cpu_we = ($urandom_range(0, 1) == 1);
                bus.ld_we = ($urandom_range(0, 1) == 1);
                bus.cpu_addr = $urandom; bus.ld_addr = $urandom;
                bus.cpu_wdata = $urandom; bus.ld_wdata = $urandom;
            end
            check("acc_mem_en", bus.mem_en, 1);
            check("acc_mem_we", bus.mem_we, ewe);
            check("acc_mem_addr", bus.mem_addr, ea);
            check("acc_mem_wdata", bus.mem_wdata, ew);
            check("acc_busy", bus.busy, 1);
            check("acc_owner", bus.owner, t.exp_owner);
            check("acc_pulses", {bus.cpu_done, bus.cpu_err, bus.ld_done, bus.ld_err}, 0);
            acked = (k == t.ack_at);
            bus.mem_ack = acked;
            bus.mem_rdata = acked ? t.rd : $urandom;
            tick();
            if (acked) break;
        end
        // RESP cycle: requesters drop req on the edge that ends it
        bus.cpu_req = 1'b0; bus.ld_req = 1'b0; bus.ld_lock = 1'b0;
        bus.mem_ack = t.scramble ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.mem_rdata = $urandom;
        check("resp_mem_en", bus.mem_en, 0);
        check("resp_mem_we", bus.mem_we, 0);
        check("resp_busy", bus.busy, 1);
        check("resp_owner", bus.owner, t.exp_owner);
        check("resp_cpu_done", bus.cpu_done, !t.exp_owner && t.exp_ok);
        check("resp_cpu_err", bus.cpu_err, !t.exp_owner && !t.exp_ok);
        check("resp_ld_done", bus.ld_done, t.exp_owner && t.exp_ok);
        check("resp_ld_err", bus.ld_err, t.exp_owner && !t.exp_ok);
        check("resp_cpu_rdata", bus.cpu_rdata, t.exp_rd_cpu);
        check("resp_ld_rdata", bus.ld_rdata, t.exp_rd_ld);
        $display("txn %0d: owner=%0b done=%0b/%0b err=%0b/%0b cpu_rdata=%08h ld_rdata=%08h",
                 idx, bus.owner, bus.cpu_done, bus.ld_done, bus.cpu_err, bus.ld_err,
                 bus.cpu_rdata, bus.ld_rdata);
        tick();
        check("post_busy", bus.busy, 0);
        check("post_pulses", {bus.cpu_done, bus.cpu_err, bus.ld_done, bus.ld_err}, 0);
        check("post_cpu_rdata", bus.cpu_rdata, t.exp_rd_cpu);
        check("post_ld_rdata", bus.ld_rdata, t.exp_rd_ld);
        clear_inputs();
    endtask

    txn_t        tbl [11];
    int          last_grant;       // -1 none since reset, 0 CPU, 1 loader
    logic [31:0] exp_rd [2];

    initial begin
        tbl[0]  = mk(1,0,0, 0,0, 32'h40, 32'h0,    32'h0,        32'h0,        2,  32'hDEADBEEF, 0, 1,0,1, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(1,1,0, 0,0, 32'h44, 32'h1000, 32'h0,        32'h0,        1,  32'h11111111, 0, 1,1,1, 32'hDEADBEEF, 32'h11111111);
        tbl[2]  = mk(1,1,0, 1,0, 32'h48, 32'h1004, 32'hAAAA0001, 32'h0,        1,  32'h0BADF00D, 0, 1,0,1, 32'hDEADBEEF, 32'h11111111);
        tbl[3]  = mk(1,1,1, 0,1, 32'h4C, 32'h1008, 32'h0,        32'hBBBB0002, 3,  32'h0BADF00D, 0, 1,1,1, 32'hDEADBEEF, 32'h11111111);
        tbl[4]  = mk(1,1,1, 0,0, 32'h50, 32'h100C, 32'h0,        32'h0,        1,  32'h22222222, 0, 1,1,1, 32'hDEADBEEF, 32'h22222222);
        tbl[5]  = mk(1,1,0, 0,0, 32'h54, 32'h1010, 32'h0,        32'h0,        1,  32'h33333333, 0, 1,0,1, 32'h33333333, 32'h22222222);
        tbl[6]  = mk(1,0,0, 1,0, 32'h80, 32'h0,    32'h12345678, 32'h0,        0,  32'h0,        0, 1,0,0, 32'h33333333, 32'h22222222);
        tbl[7]  = mk(1,0,0, 0,0, 32'h84, 32'h0,    32'h0,        32'h0,        15, 32'hCAFEF00D, 0, 1,0,1, 32'hCAFEF00D, 32'h22222222);
        tbl[8]  = mk(1,0,1, 0,0, 32'h88, 32'h0,    32'h0,        32'h0,        1,  32'h0,        0, 0,0,0, 32'hCAFEF00D, 32'h22222222);
        tbl[9]  = mk(0,1,0, 0,0, 32'h0,  32'h1014, 32'h0,        32'h0,        0,  32'h5A5A5A5A, 0, 1,1,0, 32'hCAFEF00D, 32'h22222222);
        tbl[10] = mk(1,1,0, 0,0, 32'h8C, 32'h1018, 32'h0,        32'h0,        2,  32'h55AA55AA, 1, 1,0,1, 32'h55AA55AA, 32'h22222222);

        clear_inputs();
        do_reset();
        check("rst_busy", bus.busy, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_pulses", {bus.cpu_done, bus.cpu_err, bus.ld_done, bus.ld_err}, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_ld_rdata", bus.ld_rdata, 0);

        for (int i = 0; i < 11; i++) run_txn(tbl[i], i);

        // Both requesting continuously from reset, ack held high throughout
        do_reset();
        bus.cpu_req = 1'b1; bus.ld_req = 1'b1; bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rdata = 32'hA0 + 32'(i);
            check("rr_idle_busy", bus.busy, 0);
            tick();
            check("rr_owner", bus.owner, i % 2);
            check("rr_mem_en", bus.mem_en, 1);
            tick();
            check("rr_done", {bus.cpu_done, bus.ld_done}, (i % 2 == 1) ? 2'b01 : 2'b10);
            $display("rr grant %0d: owner=%0b cpu_done=%0b ld_done=%0b", i, bus.owner, bus.cpu_done, bus.ld_done);
            tick();
        end
        clear_inputs();
        check("rr_cpu_rdata", bus.cpu_rdata, 32'hA2);
        check("rr_ld_rdata", bus.ld_rdata, 32'hA3);

        // Reset in the middle of a CPU access
        run_txn(mk(1,0,0, 0,0, 32'h90, 32'h0, 32'h0, 32'h0, 1, 32'h77, 0, 1,0,1, 32'h77, 32'hA3), 100);
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h100;
        tick();
        bus.cpu_req = 1'b0;
        check("mid_mem_en", bus.mem_en, 1);
        tick();
        #1 reset_n = 1'b0;
        #1;
        check("midrst_mem_en", bus.mem_en, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_pulses", {bus.cpu_done, bus.cpu_err, bus.ld_done, bus.ld_err}, 0);
        check("midrst_cpu_rdata", bus.cpu_rdata, 0);
        $display("mid-access reset: mem_en=%0b busy=%0b", bus.mem_en, bus.busy);
        tick();
        reset_n = 1'b1;
        tick();
        check("postrst_pulses", {bus.cpu_done, bus.cpu_err, bus.ld_done, bus.ld_err}, 0);
        check("postrst_busy", bus.busy, 0);
        run_txn(mk(1,1,0, 0,0, 32'h94, 32'h2000, 32'h0, 32'h0, 1, 32'h99, 0, 1,0,1, 32'h99, 32'h0), 101);

        // Randomized transactions against the transaction-level model
        last_grant = 0;
        exp_rd[0] = 32'h99;
        exp_rd[1] = 32'h0;
        for (int n = 0; n < 150; n++) begin
            txn_t t;
            bit   ce, le;
            int   w;
            t.c_req = ($urandom_range(0, 3) != 0);
            t.l_req = ($urandom_range(0, 1) == 1);
            t.lock  = ($urandom_range(0, 3) == 0);
            t.c_we  = ($urandom_range(0, 1) == 1);
            t.l_we  = ($urandom_range(0, 1) == 1);
            t.c_addr = $urandom; t.l_addr = $urandom;
            t.c_wd = $urandom;   t.l_wd = $urandom;
            t.rd = $urandom;
            t.scramble = ($urandom_range(0, 1) == 1);
            t.ack_at = ($urandom_range(0, 2) != 0) ? $urandom_range(1, 4) : $urandom_range(0, TIMEOUT + 1);
            ce = t.c_req && !t.lock;
            le = t.l_req;
            t.exp_grant = ce || le;
            if (ce && le) w = (last_grant == 0) ? 1 : 0;
            else          w = le ? 1 : 0;
            t.exp_owner = (w == 1);
            t.exp_ok = (t.ack_at >= 1) && (t.ack_at <= TIMEOUT);
            if (t.exp_grant) begin
                last_grant = w;
                if (t.exp_ok && !(w == 1 ? t.l_we : t.c_we)) exp_rd[w] = t.rd;
            end
            t.exp_rd_cpu = exp_rd[0];
            t.exp_rd_ld  = exp_rd[1];
            run_txn(t, 200 + n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
